// File: rtl/fpu_f32_to_f64_pipe_if.sv
// Handshake bundle for the f32->f64 converter: operand/valid/ready in, result/flags/valid/ready out.
interface fpu_f32_to_f64_pipe_if;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in;
  logic [1:0]  io_rounding_mode;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out;
  logic [4:0]  io_exception_flags;

  modport master (
    output io_in_valid, io_in, io_rounding_mode, io_out_ready,
    input  io_in_ready, io_out_valid, io_out, io_exception_flags
  );

  modport slave (
    input  io_in_valid, io_in, io_rounding_mode, io_out_ready,
    output io_in_ready, io_out_valid, io_out, io_exception_flags
  );
endinterface

// File: rtl/fpu_f32_to_f64_pipe.sv
// Exact binary32->binary64 widening, latency REG_INPUT+1, full valid/ready backpressure at 1/cycle.
// F32_TO_F64_CANON_NAN_EN: when defined every NaN result is the canonical positive quiet NaN.
module fpu_f32_to_f64_pipe #(
  parameter int REG_INPUT = 1
) (
  input logic                  clk,
  input logic                  reset,
  fpu_f32_to_f64_pipe_if.slave bus
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        is_zero;
    logic        is_sub;
    logic        is_inf;
    logic        is_nan;
    logic        is_snan;
    logic [4:0]  lz;
  } unp_t;

  typedef struct packed {
    logic [4:0]  flags;
    logic [63:0] val;
  } res_t;

  function automatic unp_t unpack(input logic [31:0] x);
    unp_t u;
    logic found;
    logic exp_zero;
    logic exp_max;
    logic frac_zero;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.frac    = x[22:0];
    exp_zero  = (x[30:23] == 8'h00);
    exp_max   = (x[30:23] == 8'hFF);
    frac_zero = (x[22:0] == 23'd0);
    u.is_zero = exp_zero && frac_zero;
    u.is_sub  = exp_zero && !frac_zero;
    u.is_inf  = exp_max && frac_zero;
    u.is_nan  = exp_max && !frac_zero;
    u.is_snan = exp_max && !frac_zero && !x[22];
    u.lz      = 5'd0;
    found     = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      u.lz = u.lz + 5'd1;
      end
    end
    return u;
  endfunction

  function automatic res_t assemble(input unp_t u);
    res_t        r;
    logic [22:0] sh;
    logic [10:0] e;
    // shifting past the leading one discards it, leaving the normalised fraction
    sh    = u.frac << (u.lz + 5'd1);
    e     = 11'd0;
    r.val = 64'd0;
    if (u.is_zero) begin
      r.val = {u.sign, 63'd0};
    end else if (u.is_inf) begin
      r.val = {u.sign, 11'h7FF, 52'd0};
    end else if (u.is_nan) begin
`ifdef F32_TO_F64_CANON_NAN_EN
      r.val = 64'h7FF8000000000000;
`else
      r.val = {u.sign, 11'h7FF, 1'b1, u.frac[21:0], 29'd0};
`endif
    end else if (u.is_sub) begin
      e     = 11'd874 + (11'd22 - {6'd0, u.lz});
      r.val = {u.sign, e, sh, 29'd0};
    end else begin
      e     = {3'd0, u.exp} + 11'd896;
      r.val = {u.sign, e, u.frac, 29'd0};
    end
    r.flags = {u.is_snan, 4'd0};
    return r;
  endfunction

  logic s1_valid;
  unp_t s1_u;
  logic in_ready;
  logic s2_en;
  logic s2_valid;
  res_t s2_res;

  // The conversion is exact, so the rounding mode is accepted but never consulted.
  logic unused_rm;
  assign unused_rm = ^bus.io_rounding_mode;

  assign s2_en = !s2_valid || bus.io_out_ready;

  if (REG_INPUT != 0) begin : g_s1_reg
    assign in_ready = !s1_valid || s2_en;

    always_ff @(posedge clk) begin
      if (reset)         s1_valid <= 1'b0;
      else if (in_ready) s1_valid <= bus.io_in_valid;
    end

    always_ff @(posedge clk) begin
      if (in_ready && bus.io_in_valid) s1_u <= unpack(bus.io_in);
    end
  end else begin : g_s1_comb
    assign in_ready = s2_en;
    assign s1_valid = bus.io_in_valid;
    assign s1_u     = unpack(bus.io_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_res <= assemble(s1_u);
    end
  end

  assign bus.io_in_ready        = in_ready;
  assign bus.io_out_valid       = s2_valid;
  assign bus.io_out             = s2_res.val;
  assign bus.io_exception_flags = s2_res.flags;

endmodule

// File: tb/tb_fpu_f32_to_f64_pipe.sv
// Directed bench for fpu_f32_to_f64_pipe (REG_INPUT=1): conversions, latency, backpressure, reset flush.
module tb_fpu_f32_to_f64_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  fpu_f32_to_f64_pipe_if bus ();

  fpu_f32_to_f64_pipe #(.REG_INPUT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef F32_TO_F64_CANON_NAN_EN
  localparam logic [63:0] SNAN_OUT = 64'h7FF8000000000000;
  localparam logic [63:0] QNAN_OUT = 64'h7FF8000000000000;
`else
  localparam logic [63:0] SNAN_OUT = 64'h7FF8000020000000;
  localparam logic [63:0] QNAN_OUT = 64'hFFF8000020000000;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with an idle pipe and io_out_ready=1.
  task automatic conv(input string tag, input logic [31:0] x,
                      input logic [63:0] e_out, input logic [4:0] e_fl);
    bus.io_in_valid      = 1'b1;
    bus.io_in            = x;
    bus.io_rounding_mode = 2'($urandom_range(3));
    #1 chk({tag, "_in_ready"}, 64'(bus.io_in_ready), 64'd1);
    @(negedge clk);
    bus.io_in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(bus.io_out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_lat2_valid"}, 64'(bus.io_out_valid), 64'd1);
    chk({tag, "_out"}, bus.io_out, e_out);
    chk({tag, "_flags"}, 64'(bus.io_exception_flags), 64'(e_fl));
  endtask

  initial begin
    bus.io_in_valid      = 1'b0;
    bus.io_in            = 32'd0;
    bus.io_rounding_mode = 2'd0;
    bus.io_out_ready     = 1'b1;
    reset                = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.io_out_valid), 64'd0);
    chk("rst_out", bus.io_out, 64'd0);
    chk("rst_flags", 64'(bus.io_exception_flags), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.io_in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(bus.io_out_valid), 64'd0);

    conv("one",      32'h3F800000, 64'h3FF0000000000000, 5'b00000);
    conv("min_sub",  32'h00000001, 64'h36A0000000000000, 5'b00000);
    conv("max_sub",  32'h007FFFFF, 64'h380FFFFFC0000000, 5'b00000);
    conv("hi_sub",   32'h00400000, 64'h3800000000000000, 5'b00000);
    conv("min_norm", 32'h00800000, 64'h3810000000000000, 5'b00000);
    conv("max_norm", 32'h7F7FFFFF, 64'h47EFFFFFE0000000, 5'b00000);
    conv("neg_pi",   32'hC0490FDB, 64'hC00921FB60000000, 5'b00000);
    conv("neg_inf",  32'hFF800000, 64'hFFF0000000000000, 5'b00000);
    conv("neg_zero", 32'h80000000, 64'h8000000000000000, 5'b00000);
    conv("snan",     32'h7F800001, SNAN_OUT,             5'b10000);
    conv("qnan",     32'hFFC00001, QNAN_OUT,             5'b00000);

    // Backpressure: three back-to-back inputs with the consumer stalled.
    @(negedge clk);
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 1'b1;
    bus.io_in        = 32'h3F800000;
    #1 chk("bp_a_ready", 64'(bus.io_in_ready), 64'd1);
    @(negedge clk);
    chk("bp_b_ready", 64'(bus.io_in_ready), 64'd1);
    chk("bp_b_out_valid", 64'(bus.io_out_valid), 64'd0);
    bus.io_in = 32'h40000000;
    @(negedge clk);
    chk("bp_c_ready", 64'(bus.io_in_ready), 64'd0);
    chk("bp_c_out_valid", 64'(bus.io_out_valid), 64'd1);
    chk("bp_c_out", bus.io_out, 64'h3FF0000000000000);
    bus.io_in = 32'hBF800000;
    @(negedge clk);
    chk("bp_hold_ready", 64'(bus.io_in_ready), 64'd0);
    chk("bp_hold_out", bus.io_out, 64'h3FF0000000000000);
    @(negedge clk);
    chk("bp_hold2_ready", 64'(bus.io_in_ready), 64'd0);
    chk("bp_hold2_flags", 64'(bus.io_exception_flags), 64'd0);
    bus.io_out_ready = 1'b1;
    #1 chk("drain_ready", 64'(bus.io_in_ready), 64'd1);
    chk("drain_a", bus.io_out, 64'h3FF0000000000000);
    @(negedge clk);
    bus.io_in_valid = 1'b0;
    chk("drain_b_valid", 64'(bus.io_out_valid), 64'd1);
    chk("drain_b", bus.io_out, 64'h4000000000000000);
    @(negedge clk);
    chk("drain_c_valid", 64'(bus.io_out_valid), 64'd1);
    chk("drain_c", bus.io_out, 64'hBFF0000000000000);
    @(negedge clk);
    chk("drain_empty", 64'(bus.io_out_valid), 64'd0);

    // Reset with two conversions in flight.
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 1'b1;
    bus.io_in        = 32'h3F800000;
    @(negedge clk);
    bus.io_in = 32'h40000000;
    @(negedge clk);
    bus.io_in_valid = 1'b0;
    chk("inflight_valid", 64'(bus.io_out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("flush_out_valid", 64'(bus.io_out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.io_in_ready), 64'd1);
    chk("flush_out", bus.io_out, 64'd0);
    bus.io_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_no_stale", 64'(bus.io_out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
